multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 81 ++++++++
 rtl/alu_op_decoder.sv | 34 +++
 rtl/multicycle_controller.sv | 167 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller and its ALU: states, opcode/funct values, ALU codes.
package multicycle_controller_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 3;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_I_EXEC   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  typedef enum logic [ALU_W-1:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3,
    ALU_SLT = 3'd7
  } alu_op_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] FN_JR  = 6'h08;
  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  // ALU B-operand, write-back and PC source selector encodings
  localparam logic [SEL_W-1:0] ASB_REG  = 2'b00;
  localparam logic [SEL_W-1:0] ASB_FOUR = 2'b01;
  localparam logic [SEL_W-1:0] ASB_IMM  = 2'b10;
  localparam logic [SEL_W-1:0] ASB_BR   = 2'b11;
  localparam logic [SEL_W-1:0] MTR_ALU  = 2'b00;
  localparam logic [SEL_W-1:0] MTR_MEM  = 2'b01;
  localparam logic [SEL_W-1:0] MTR_PC   = 2'b10;
  localparam logic [SEL_W-1:0] PCS_INC  = 2'b00;
  localparam logic [SEL_W-1:0] PCS_BR   = 2'b01;
  localparam logic [SEL_W-1:0] PCS_JMP  = 2'b10;
  localparam logic [SEL_W-1:0] PCS_JR   = 2'b11;

  // Full control word driven by the controller each cycle
  typedef struct packed {
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic             i_or_d;
    logic             reg_dst;
    logic             alu_src_a;
    logic             pc_load;
    logic             illegal;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] mem_to_reg;
    logic [SEL_W-1:0] pc_src;
    alu_op_t          alu_op;
  } ctrl_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Maps an R-type funct or I-type opcode onto an ALU operation; valid flags a recognised ALU instruction.
module alu_op_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [OP_W-1:0] i_opcode,
  input  logic [OP_W-1:0] i_funct,
  output alu_op_t         o_alu_op_c,
  output logic            o_valid_c
);

  // Opcode/funct lookup; jr is not an ALU instruction and stays invalid here
  always_comb begin
    o_alu_op_c = ALU_AND;
    o_valid_c  = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD:  begin o_alu_op_c = ALU_ADD; o_valid_c = 1'b1; end
          FN_SUB:  begin o_alu_op_c = ALU_SUB; o_valid_c = 1'b1; end
          FN_AND:  begin o_alu_op_c = ALU_AND; o_valid_c = 1'b1; end
          FN_OR:   begin o_alu_op_c = ALU_OR;  o_valid_c = 1'b1; end
          FN_SLT:  begin o_alu_op_c = ALU_SLT; o_valid_c = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI: begin o_alu_op_c = ALU_ADD; o_valid_c = 1'b1; end
      OP_SLTI: begin o_alu_op_c = ALU_SLT; o_valid_c = 1'b1; end
      OP_ANDI: begin o_alu_op_c = ALU_AND; o_valid_c = 1'b1; end
      OP_ORI:  begin o_alu_op_c = ALU_OR;  o_valid_c = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: Moore decode of the state, with fetch and branch PC strobes
// qualified combinationally by mem_ready and zero.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  opcode,
  input  logic [OP_W-1:0]  funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             i_or_d,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic             pc_load,
  output logic             illegal,
  output logic [SEL_W-1:0] alu_src_b,
  output logic [SEL_W-1:0] mem_to_reg,
  output logic [SEL_W-1:0] pc_src,
  output logic [ALU_W-1:0] alu_operation
);

  state_t  r_state;
  state_t  w_next;
  ctrl_t   w_ctl;
  alu_op_t w_dec_alu;
  logic    w_dec_valid;
  logic    w_is_jr;
  logic    w_is_mem;
  logic    w_is_br;
  logic    w_is_jmp;
  logic    w_known;

  alu_op_decoder u_alu_op_decoder (
    .i_opcode   (opcode),
    .i_funct    (funct),
    .o_alu_op_c (w_dec_alu),
    .o_valid_c  (w_dec_valid)
  );

  // Instruction classification from the held instruction register fields
  assign w_is_jr  = (opcode == OP_RTYPE) && (funct == FN_JR);
  assign w_is_mem = (opcode == OP_LW) || (opcode == OP_SW);
  assign w_is_br  = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign w_is_jmp = (opcode == OP_J) || (opcode == OP_JAL);
  assign w_known  = w_dec_valid | w_is_jr | w_is_mem | w_is_br | w_is_jmp;

  // State register; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_RESET;
    else      r_state <= w_next;
  end

  // Next-state and control-word decode
  always_comb begin
    w_next = r_state;
    w_ctl  = '0;
    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: begin
        w_ctl.mem_read  = 1'b1;
        w_ctl.alu_src_b = ASB_FOUR;
        w_ctl.alu_op    = ALU_ADD;
        w_ctl.pc_src    = PCS_INC;
        w_ctl.ir_write  = mem_ready;
        w_ctl.pc_load   = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_ctl.alu_src_b = ASB_BR;
        w_ctl.alu_op    = ALU_ADD;
        w_ctl.illegal   = ILLEGAL_TRAP & ~w_known;
        if (w_is_jr)                               w_next = S_JUMP;
        else if (w_dec_valid && opcode == OP_RTYPE) w_next = S_R_EXEC;
        else if (w_dec_valid)                      w_next = S_I_EXEC;
        else if (w_is_mem)                         w_next = S_MEM_ADDR;
        else if (w_is_br)                          w_next = S_BRANCH;
        else if (w_is_jmp)                         w_next = S_JUMP;
        else                                       w_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = ASB_IMM;
        w_ctl.alu_op    = ALU_ADD;
        w_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        w_ctl.mem_read = 1'b1;
        w_ctl.i_or_d   = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WR: begin
        w_ctl.mem_write = 1'b1;
        w_ctl.i_or_d    = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_MEM_WB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.mem_to_reg = MTR_MEM;
        w_next = S_FETCH;
      end
      S_R_EXEC: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = ASB_REG;
        w_ctl.alu_op    = w_dec_alu;
        w_next = S_R_WB;
      end
      S_R_WB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.reg_dst    = 1'b1;
        w_ctl.mem_to_reg = MTR_ALU;
        w_next = S_FETCH;
      end
      S_I_EXEC: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = ASB_IMM;
        w_ctl.alu_op    = w_dec_alu;
        w_next = S_I_WB;
      end
      S_I_WB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.mem_to_reg = MTR_ALU;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = ASB_REG;
        w_ctl.alu_op    = ALU_SUB;
        w_ctl.pc_src    = PCS_BR;
        w_ctl.pc_load   = (opcode == OP_BEQ) ? zero : ~zero;
        w_next = S_FETCH;
      end
      S_JUMP: begin
        w_ctl.pc_load = 1'b1;
        w_ctl.pc_src  = (opcode == OP_RTYPE) ? PCS_JR : PCS_JMP;
        if (opcode == OP_JAL) begin
          w_ctl.reg_write  = 1'b1;
          w_ctl.mem_to_reg = MTR_PC;
        end
        w_next = S_FETCH;
      end
      default: w_next = S_RESET;
    endcase
  end

  // Control word onto the ports
  assign mem_read      = w_ctl.mem_read;
  assign mem_write     = w_ctl.mem_write;
  assign ir_write      = w_ctl.ir_write;
  assign reg_write     = w_ctl.reg_write;
  assign i_or_d        = w_ctl.i_or_d;
  assign reg_dst       = w_ctl.reg_dst;
  assign alu_src_a     = w_ctl.alu_src_a;
  assign pc_load       = w_ctl.pc_load;
  assign illegal       = w_ctl.illegal;
  assign alu_src_b     = w_ctl.alu_src_b;
  assign mem_to_reg    = w_ctl.mem_to_reg;
  assign pc_src        = w_ctl.pc_src;
  assign alu_operation = w_ctl.alu_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios plus random instruction streams
// checked against a per-instruction cycle-sequence model.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       i_or_d;
    logic       reg_dst;
    logic       alu_src_a;
    logic       pc_load;
    logic       illegal;
    logic [1:0] alu_src_b;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, ir_write, reg_write, i_or_d, reg_dst, alu_src_a, pc_load, illegal;
  logic [1:0] alu_src_b, mem_to_reg, pc_src;
  logic [2:0] alu_operation;
  ctl_t       obs;

  int checks = 0;
  int errors = 0;

  ctl_t q_exp[$];
  bit   q_rdy[$];

  logic [5:0] op_pool [12] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08,
                               6'h0A, 6'h0C, 6'h0D, 6'h02, 6'h03, 6'h3F};
  logic [5:0] fn_pool [7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h00};

  always #5 clk = ~clk;

  multicycle_controller #(.ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .i_or_d(i_or_d), .reg_dst(reg_dst), .alu_src_a(alu_src_a), .pc_load(pc_load),
    .illegal(illegal), .alu_src_b(alu_src_b), .mem_to_reg(mem_to_reg), .pc_src(pc_src),
    .alu_operation(alu_operation)
  );

  assign obs = {mem_read, mem_write, ir_write, reg_write, i_or_d, reg_dst, alu_src_a, pc_load,
                illegal, alu_src_b, mem_to_reg, pc_src, alu_operation};

  function automatic void push(input ctl_t c, input bit rdy);
    q_exp.push_back(c);
    q_rdy.push_back(rdy);
  endfunction

  // Expected per-cycle control words of one instruction, from the ISA's description of each class
  function automatic void model(input logic [5:0] op, input logic [5:0] fn, input bit z,
                                input int fw, input int mw);
    ctl_t       c;
    logic [2:0] alu;
    bit         alu_ok;
    bit         known;
    alu_ok = 1'b1;
    alu    = 3'd0;
    if (op == 6'h00) begin
      case (fn)
        6'h20: alu = 3'd2;
        6'h22: alu = 3'd3;
        6'h24: alu = 3'd0;
        6'h25: alu = 3'd1;
        6'h2A: alu = 3'd7;
        default: alu_ok = 1'b0;
      endcase
    end else begin
      case (op)
        6'h08: alu = 3'd2;
        6'h0A: alu = 3'd7;
        6'h0C: alu = 3'd0;
        6'h0D: alu = 3'd1;
        default: alu_ok = 1'b0;
      endcase
    end
    for (int i = 0; i <= fw; i++) begin
      c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_op = 3'd2;
      c.ir_write = (i == fw); c.pc_load = (i == fw);
      push(c, i == fw);
    end
    known = alu_ok || (op == 6'h00 && fn == 6'h08) || op == 6'h23 || op == 6'h2B ||
            op == 6'h04 || op == 6'h05 || op == 6'h02 || op == 6'h03;
    c = '0; c.alu_src_b = 2'b11; c.alu_op = 3'd2; c.illegal = !known;
    push(c, 1'($urandom_range(1, 0)));
    if (!known) return;
    if (alu_ok) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_src_b = (op == 6'h00) ? 2'b00 : 2'b10; c.alu_op = alu;
      push(c, 1'($urandom_range(1, 0)));
      c = '0; c.reg_write = 1'b1; c.reg_dst = (op == 6'h00);
      push(c, 1'($urandom_range(1, 0)));
    end else if (op == 6'h00 || op == 6'h02 || op == 6'h03) begin
      c = '0; c.pc_load = 1'b1; c.pc_src = (op == 6'h00) ? 2'b11 : 2'b10;
      if (op == 6'h03) begin c.reg_write = 1'b1; c.mem_to_reg = 2'b10; end
      push(c, 1'($urandom_range(1, 0)));
    end else if (op == 6'h23 || op == 6'h2B) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 3'd2;
      push(c, 1'($urandom_range(1, 0)));
      for (int i = 0; i <= mw; i++) begin
        c = '0; c.i_or_d = 1'b1; c.mem_read = (op == 6'h23); c.mem_write = (op == 6'h2B);
        push(c, i == mw);
      end
      if (op == 6'h23) begin
        c = '0; c.reg_write = 1'b1; c.mem_to_reg = 2'b01;
        push(c, 1'($urandom_range(1, 0)));
      end
    end else begin
      c = '0; c.alu_src_a = 1'b1; c.alu_op = 3'd3; c.pc_src = 2'b01;
      c.pc_load = (op == 6'h04) ? z : !z;
      push(c, 1'($urandom_range(1, 0)));
    end
  endfunction

  task automatic test_reset();
    ctl_t e;
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_async got %h exp 0", obs); end
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_held got %h exp 0", obs); end
    rst = 1'b1; mem_ready = 1'b0; #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_cycle got %h exp 0", obs); end
    @(negedge clk); #1;
    e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_op = 3'd2;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_to_fetch got %h exp %h", obs, e); end
    @(negedge clk);
  endtask

  task automatic test_rtype_sub();
    opcode = 6'h00; funct = 6'h22; zero = 1'b0; mem_ready = 1'b1; #1;
    checks++;
    if ({mem_read, ir_write, pc_load, alu_src_b, alu_operation} !== {3'b111, 2'b01, 3'd2}) begin
      errors++; $display("FAIL rsub_fetch got %b%b%b %b %0d", mem_read, ir_write, pc_load, alu_src_b, alu_operation);
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    checks++;
    if ({alu_src_a, alu_src_b, alu_operation, illegal} !== {1'b0, 2'b11, 3'd2, 1'b0}) begin
      errors++; $display("FAIL rsub_decode got %b %b %0d %b", alu_src_a, alu_src_b, alu_operation, illegal);
    end
    @(negedge clk); #1;
    checks++;
    if ({alu_src_a, alu_src_b, alu_operation, reg_write} !== {1'b1, 2'b00, 3'd3, 1'b0}) begin
      errors++; $display("FAIL rsub_exec got %b %b %0d %b", alu_src_a, alu_src_b, alu_operation, reg_write);
    end
    @(negedge clk); #1;
    checks++;
    if ({reg_write, reg_dst, mem_to_reg, mem_write, pc_load} !== {1'b1, 1'b1, 2'b00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rsub_wb got %b %b %b %b %b", reg_write, reg_dst, mem_to_reg, mem_write, pc_load);
    end
    @(negedge clk); #1;
    checks++;
    if ({mem_read, alu_src_b, reg_write} !== {1'b1, 2'b01, 1'b0}) begin
      errors++; $display("FAIL rsub_refetch got %b %b %b", mem_read, alu_src_b, reg_write);
    end
    @(negedge clk);
  endtask

  task automatic test_lw_wait();
    opcode = 6'h23; funct = 6'h00; mem_ready = 1'b1; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if ({alu_src_a, alu_src_b, alu_operation} !== {1'b1, 2'b10, 3'd2}) begin
      errors++; $display("FAIL lw_addr got %b %b %0d", alu_src_a, alu_src_b, alu_operation);
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3); #1;
      checks++;
      if ({mem_read, i_or_d, mem_write, reg_write} !== 4'b1100) begin
        errors++; $display("FAIL lw_memrd[%0d] got %b%b%b%b exp 1100", k, mem_read, i_or_d, mem_write, reg_write);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0; #1;
    checks++;
    if ({reg_write, reg_dst, mem_to_reg, mem_read} !== {1'b1, 1'b0, 2'b01, 1'b0}) begin
      errors++; $display("FAIL lw_wb got %b %b %b %b", reg_write, reg_dst, mem_to_reg, mem_read);
    end
    @(negedge clk); #1;
    checks++;
    if ({mem_read, ir_write, i_or_d} !== 3'b100) begin
      errors++; $display("FAIL lw_refetch got %b%b%b exp 100", mem_read, ir_write, i_or_d);
    end
    @(negedge clk);
  endtask

  task automatic test_branch();
    opcode = 6'h04; mem_ready = 1'b1; #1;
    @(negedge clk); #1;
    @(negedge clk); zero = 1'b1; #1;
    checks++;
    if ({pc_load, pc_src, alu_operation} !== {1'b1, 2'b01, 3'd3}) begin
      errors++; $display("FAIL beq_taken got %b %b %0d", pc_load, pc_src, alu_operation);
    end
    zero = 1'b0; #1;
    checks++;
    if (pc_load !== 1'b0) begin errors++; $display("FAIL beq_zero_comb got %b exp 0", pc_load); end
    @(negedge clk);
    opcode = 6'h05; mem_ready = 1'b1; #1;
    @(negedge clk); #1;
    @(negedge clk); zero = 1'b1; #1;
    checks++;
    if ({pc_load, pc_src} !== {1'b0, 2'b01}) begin
      errors++; $display("FAIL bne_not_taken got %b %b", pc_load, pc_src);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    opcode = 6'h3F; mem_ready = 1'b1; #1;
    @(negedge clk); mem_ready = 1'b0; #1;
    checks++;
    if ({illegal, mem_write, reg_write, pc_load, ir_write} !== 5'b10000) begin
      errors++; $display("FAIL illegal_decode got %b%b%b%b%b exp 10000", illegal, mem_write, reg_write, pc_load, ir_write);
    end
    @(negedge clk); #1;
    checks++;
    if ({illegal, mem_read, alu_src_b} !== {1'b0, 1'b1, 2'b01}) begin
      errors++; $display("FAIL illegal_refetch got %b %b %b", illegal, mem_read, alu_src_b);
    end
    @(negedge clk);
  endtask

  task automatic test_jal();
    opcode = 6'h03; mem_ready = 1'b1; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if ({pc_load, pc_src, reg_write, mem_to_reg, reg_dst} !== {1'b1, 2'b10, 1'b1, 2'b10, 1'b0}) begin
      errors++; $display("FAIL jal_jump got %b %b %b %b %b", pc_load, pc_src, reg_write, mem_to_reg, reg_dst);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    opcode = 6'h23; mem_ready = 1'b1; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); mem_ready = 1'b0; #1;
    checks++;
    if ({mem_read, i_or_d} !== 2'b11) begin
      errors++; $display("FAIL midrst_in_memrd got %b%b exp 11", mem_read, i_or_d);
    end
    rst = 1'b0; #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL midrst_async got %h exp 0", obs); end
    @(negedge clk); rst = 1'b1; #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL midrst_reset_cycle got %h exp 0", obs); end
    @(negedge clk); #1;
    checks++;
    if ({mem_read, i_or_d, alu_src_b} !== {1'b1, 1'b0, 2'b01}) begin
      errors++; $display("FAIL midrst_fetch got %b %b %b", mem_read, i_or_d, alu_src_b);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [5:0]  op, fn;
    bit          z;
    int unsigned k;
    for (int n = 0; n < 80; n++) begin
      k  = $urandom_range(12, 0);
      op = (k == 12) ? 6'($urandom) : op_pool[k];
      k  = $urandom_range(7, 0);
      fn = (k == 7) ? 6'($urandom) : fn_pool[k];
      z  = 1'($urandom_range(1, 0));
      model(op, fn, z, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)));
      opcode = op; funct = fn; zero = z;
      while (q_exp.size() > 0) begin
        ctl_t e;
        e = q_exp.pop_front();
        mem_ready = q_rdy.pop_front();
        #1;
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL random[%0d] op=%h fn=%h z=%b got %h exp %h", n, op, fn, z, obs, e);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype_sub();
    test_lw_wait();
    test_branch();
    test_illegal();
    test_jal();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
